// File: rtl/scc_pkg.sv
// Shared types and constants for the SCC memory/writeback stage: memory-op
// encoding, stage FSM encoding, flag bit positions and default widths.
package scc_pkg;

  localparam int SCC_DATA_W = 16;
  localparam int SCC_REG_AW = 3;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_op_t;

  typedef enum logic [1:0] {
    WB_IDLE   = 2'd0,
    WB_ACCESS = 2'd1,
    WB_COMMIT = 2'd2
  } wb_state_t;

  // Bit positions inside the {N,Z,C,V} flags word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // The reserved encoding is treated like "none": only load/store touch memory.
  function automatic logic is_mem_access(input logic [1:0] op);
    return (op == MEM_LOAD) || (op == MEM_STORE);
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Memory request/acknowledge port of the SCC memory/writeback stage.
// The stage is the master; the memory system is the slave.
interface mem_wb_stage_if #(
  parameter int DATA_W = 16
) ();
  // Handshake: the master raises mem_req with mem_we/mem_addr/mem_wdata and
  // holds all four stable until it samples mem_ack high on a rising edge;
  // mem_rdata is only meaningful in that same cycle, and mem_req drops the
  // cycle after the ack.
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/scc_reg_file.sv
// 2**REG_AW x DATA_W register file: two combinational read ports, one
// synchronous write port. Define WB_BYPASS_EN to forward same-cycle writes.
module scc_reg_file
  import scc_pkg::*;
#(
  parameter int DATA_W = SCC_DATA_W,
  parameter int REG_AW = SCC_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  localparam int DEPTH = 1 << REG_AW;

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wr_addr] <= wr_data;
    end
  end

`ifdef WB_BYPASS_EN
  // A read of the register being committed sees the incoming value.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    if (we && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
    if (we && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
  end
`else
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
  end
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// SCC memory-access and writeback stage: optional load/store over a req/ack
// port, then commit to the register file and flags. Optional: WB_BYPASS_EN.
module mem_wb_stage
  import scc_pkg::*;
#(
  parameter int DATA_W = SCC_DATA_W,
  parameter int REG_AW = SCC_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  // Execute -> stage: an instruction transfers on a rising edge where
  // ex_valid and ex_ready are both high; ex_ready does not depend on ex_valid.
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [REG_AW-1:0] ex_dest_reg,
  input  logic              ex_wr_en,
  input  logic [3:0]        ex_flags,
  input  logic              ex_flags_en,
  input  logic [1:0]        ex_mem_op,
  input  logic [DATA_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_store_data,
  mem_wb_stage_if.master    mem,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [3:0]        flags,
  output logic [15:0]       retire_count,
  output logic [1:0]        state
);

  localparam logic [1:0] IDLE   = 2'(WB_IDLE);
  localparam logic [1:0] ACCESS = 2'(WB_ACCESS);
  localparam logic [1:0] COMMIT = 2'(WB_COMMIT);

  logic              accept;
  logic              commit;
  logic              lat_is_load;
  logic              lat_is_store;
  logic              reg_we;
  logic              flags_we;
  logic [3:0]        flags_q;

  logic [DATA_W-1:0] lat_result;
  logic [REG_AW-1:0] lat_dest;
  logic              lat_wr_en;
  logic [3:0]        lat_flags;
  logic              lat_flags_en;
  logic [1:0]        lat_mem_op;

  assign ex_ready     = (state != ACCESS);
  assign accept       = ex_valid & ex_ready;
  assign commit       = (state == COMMIT);
  assign lat_is_load  = (lat_mem_op == MEM_LOAD);
  assign lat_is_store = (lat_mem_op == MEM_STORE);
  assign reg_we       = commit & lat_wr_en & ~lat_is_store;
  assign flags_we     = commit & lat_flags_en & ~lat_is_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      flags_q       <= '0;
      retire_count  <= '0;
      lat_result    <= '0;
      lat_dest      <= '0;
      lat_wr_en     <= 1'b0;
      lat_flags     <= '0;
      lat_flags_en  <= 1'b0;
      lat_mem_op    <= '0;
    end else begin
      if (flags_we) flags_q <= lat_flags;
      if (commit)   retire_count <= retire_count + 16'd1;

      case (state)
        ACCESS: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            if (lat_is_load) lat_result <= mem.mem_rdata;
            state <= COMMIT;
          end
        end
        default: begin
          // IDLE and COMMIT both accept; in COMMIT the retiring instruction's
          // fields are consumed this edge, so overwriting them is safe.
          if (accept) begin
            lat_result   <= ex_result;
            lat_dest     <= ex_dest_reg;
            lat_wr_en    <= ex_wr_en;
            lat_flags    <= ex_flags;
            lat_flags_en <= ex_flags_en;
            lat_mem_op   <= ex_mem_op;
            if (is_mem_access(ex_mem_op)) begin
              state         <= ACCESS;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= (ex_mem_op == MEM_STORE);
              mem.mem_addr  <= ex_addr;
              mem.mem_wdata <= ex_store_data;
            end else begin
              state <= COMMIT;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  assign flags = flags_we ? lat_flags : flags_q;
`else
  assign flags = flags_q;
`endif

  scc_reg_file #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .we        (reg_we),
    .wr_addr   (lat_dest),
    .wr_data   (lat_result),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table with a commit scoreboard,
// a memory responder, and hand-written reset/bypass/wrap sequences.
module tb_mem_wb_stage;
  import scc_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ex_valid, ex_ready, ex_wr_en, ex_flags_en;
  logic [DW-1:0] ex_result, ex_addr, ex_store_data;
  logic [AW-1:0] ex_dest_reg, rd_addr_a, rd_addr_b;
  logic [3:0]    ex_flags, flags;
  logic [1:0]    ex_mem_op, state;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic [15:0]   retire_count;

  mem_wb_stage_if #(.DATA_W(DW)) mem_bus ();

  mem_wb_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_result     (ex_result),
    .ex_dest_reg   (ex_dest_reg),
    .ex_wr_en      (ex_wr_en),
    .ex_flags      (ex_flags),
    .ex_flags_en   (ex_flags_en),
    .ex_mem_op     (ex_mem_op),
    .ex_addr       (ex_addr),
    .ex_store_data (ex_store_data),
    .mem           (mem_bus),
    .rd_addr_a     (rd_addr_a),
    .rd_addr_b     (rd_addr_b),
    .rd_data_a     (rd_data_a),
    .rd_data_b     (rd_data_b),
    .flags         (flags),
    .retire_count  (retire_count),
    .state         (state)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [AW-1:0] dest;
    logic [DW-1:0] result;
    logic          wr_en;
    logic [3:0]    flg;
    logic          flg_en;
    logic [1:0]    op;
    logic [DW-1:0] addr;
    logic [DW-1:0] sdata;
    logic [DW-1:0] rdata;
    int            dly;
    logic [DW-1:0] exp_val;
    logic [3:0]    exp_flg;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] dest;
    logic [DW-1:0] val;
    logic [3:0]    flg;
    logic [15:0]   cnt;
  } exp_t;

  typedef struct {
    logic [DW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            dly;
  } acc_t;

  exp_t exp_q[$];
  acc_t acc_q[$];

  bit resp_en    = 1'b1;
  bit monitor_en = 1'b1;
  bit stray_ack  = 1'b0;
  bit timed_out  = 1'b0;

  function automatic vec_t mk(input logic [AW-1:0] dest, input logic [DW-1:0] result,
                              input logic wr_en, input logic [3:0] flg, input logic flg_en,
                              input logic [1:0] op, input logic [DW-1:0] addr,
                              input logic [DW-1:0] sdata, input logic [DW-1:0] rdata,
                              input int dly, input logic [DW-1:0] exp_val,
                              input logic [3:0] exp_flg);
    vec_t v;
    v.dest = dest; v.result = result; v.wr_en = wr_en; v.flg = flg; v.flg_en = flg_en;
    v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.dly = dly;
    v.exp_val = exp_val; v.exp_flg = exp_flg;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input vec_t v, input logic [15:0] exp_cnt, input bit push);
    int budget;
    acc_t a;
    ex_dest_reg   = v.dest;
    ex_result     = v.result;
    ex_wr_en      = v.wr_en;
    ex_flags      = v.flg;
    ex_flags_en   = v.flg_en;
    ex_mem_op     = v.op;
    ex_addr       = v.addr;
    ex_store_data = v.sdata;
    ex_valid      = 1'b1;
    if (push) begin
      exp_q.push_back(exp_t'{v.dest, v.exp_val, v.exp_flg, exp_cnt});
      if (v.op == MEM_LOAD || v.op == MEM_STORE) begin
        a.addr = v.addr; a.we = (v.op == MEM_STORE); a.wdata = v.sdata;
        a.rdata = v.rdata; a.dly = v.dly;
        acc_q.push_back(a);
      end
    end
    budget = 0;
    @(negedge clk);
    while (!ex_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!ex_ready) begin
      check("accept_timeout", {31'd0, ex_ready}, 32'd1);
      timed_out = 1'b1;
      ex_valid  = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    acc_t cur;
    bit   in_acc;
    bit   ack_last;
    int   req_cycles;
    in_acc = 0; ack_last = 0; req_cycles = 0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_bus.mem_ack   = stray_ack;
      mem_bus.mem_rdata = DW'($urandom);
      if (ack_last) begin
        check("mem_req_drop", {31'd0, mem_bus.mem_req}, 32'd0);
        ack_last = 0;
      end
      if (rst) begin
        in_acc = 0;
      end else if (mem_bus.mem_req && resp_en) begin
        if (!in_acc) begin
          if (acc_q.size() == 0) check("mem_req_unexpected", {31'd0, mem_bus.mem_req}, 32'd0);
          else begin
            cur = acc_q.pop_front();
            in_acc = 1; req_cycles = 0;
          end
        end
        if (in_acc) begin
          req_cycles++;
          check("mem_addr", {16'd0, mem_bus.mem_addr}, {16'd0, cur.addr});
          check("mem_we", {31'd0, mem_bus.mem_we}, {31'd0, cur.we});
          if (cur.we) check("mem_wdata", {16'd0, mem_bus.mem_wdata}, {16'd0, cur.wdata});
          check("ex_ready_in_access", {31'd0, ex_ready}, 32'd0);
          if (req_cycles == cur.dly + 1) begin
            mem_bus.mem_ack   = 1'b1;
            mem_bus.mem_rdata = cur.rdata;
            in_acc   = 0;
            ack_last = 1;
          end
        end
      end
    end
  end

  // ---------------- commit scoreboard ----------------
  initial begin : monitor
    exp_t e;
    bit   pend;
    pend = 0;
    rd_addr_b = '0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("retire_count", {16'd0, retire_count}, {16'd0, e.cnt});
`ifndef WB_BYPASS_EN
        check("commit_reg", {16'd0, rd_data_b}, {16'd0, e.val});
        check("commit_flags", {28'd0, flags}, {28'd0, e.flg});
`endif
        pend = 0;
      end
      if (!rst && monitor_en && state == 2'd2) begin
        if (exp_q.size() == 0) begin
          check("unexpected_commit", {30'd0, state}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          rd_addr_b = e.dest;
`ifdef WB_BYPASS_EN
          #1;
          check("commit_reg", {16'd0, rd_data_b}, {16'd0, e.val});
          check("commit_flags", {28'd0, flags}, {28'd0, e.flg});
`endif
          pend = 1;
        end
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  vec_t vecs[12];
  vec_t nop;

  initial begin : main
    rst = 1'b1;
    ex_valid = 1'b0; ex_result = '0; ex_dest_reg = '0; ex_wr_en = 1'b0;
    ex_flags = '0; ex_flags_en = 1'b0; ex_mem_op = '0; ex_addr = '0; ex_store_data = '0;
    rd_addr_a = '0;

    //            dest  result    wr flags    fen op         addr      sdata     rdata     dly exp_val   exp_flg
    vecs[0]  = mk(3'd3, 16'h1234, 1, 4'b0100, 1, MEM_NONE,  16'h0000, 16'h0000, 16'h0000, 0, 16'h1234, 4'b0100);
    vecs[1]  = mk(3'd5, 16'h9999, 1, 4'b1111, 1, MEM_LOAD,  16'h0040, 16'h0000, 16'hBEEF, 2, 16'hBEEF, 4'b0100);
    vecs[2]  = mk(3'd2, 16'h7777, 1, 4'b0000, 0, MEM_STORE, 16'h0010, 16'hA5A5, 16'h0000,
                  int'($urandom_range(0, 3)), 16'h0000, 4'b0100);
    vecs[3]  = mk(3'd1, 16'h0001, 1, 4'b0000, 0, MEM_NONE,  16'h0000, 16'h0000, 16'h0000, 0, 16'h0001, 4'b0100);
    vecs[4]  = mk(3'd1, 16'h0002, 1, 4'b1001, 1, MEM_NONE,  16'h0000, 16'h0000, 16'h0000, 0, 16'h0002, 4'b1001);
    vecs[5]  = mk(3'd7, 16'hFFFF, 1, 4'b0010, 1, MEM_RSVD,  16'h9999, 16'h0000, 16'h0000, 0, 16'hFFFF, 4'b0010);
    vecs[6]  = mk(3'd0, 16'h00AA, 1, 4'b0000, 0, MEM_NONE,  16'h0000, 16'h0000, 16'h0000, 0, 16'h00AA, 4'b0010);
    vecs[7]  = mk(3'd3, 16'h5555, 0, 4'b0001, 1, MEM_NONE,  16'h0000, 16'h0000, 16'h0000, 0, 16'h1234, 4'b0001);
    vecs[8]  = mk(3'd6, 16'h0000, 0, 4'b0000, 0, MEM_LOAD,  16'h0123, 16'h0000, 16'h4321, 0, 16'h0000, 4'b0001);
    vecs[9]  = mk(3'd3, 16'h0000, 1, 4'b1000, 1, MEM_LOAD,  16'hFFFE, 16'h0000, 16'h0F0F,
                  int'($urandom_range(1, 3)), 16'h0F0F, 4'b0001);
    vecs[10] = mk(3'd4, 16'h0000, 0, 4'b0110, 0, MEM_STORE, 16'h0002, 16'h1357, 16'h0000, 1, 16'h0000, 4'b0001);
    vecs[11] = mk(3'd2, 16'h2222, 1, 4'b0000, 1, MEM_NONE,  16'h0000, 16'h0000, 16'h0000, 0, 16'h2222, 4'b0000);
    nop      = mk(3'd0, 16'h0000, 0, 4'b0000, 0, MEM_NONE,  16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 4'b0000);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ex_ready", {31'd0, ex_ready}, 32'd1);
    check("reset_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
    check("reset_mem_we", {31'd0, mem_bus.mem_we}, 32'd0);
    check("reset_mem_addr", {16'd0, mem_bus.mem_addr}, 32'd0);
    check("reset_mem_wdata", {16'd0, mem_bus.mem_wdata}, 32'd0);
    check("reset_flags", {28'd0, flags}, 32'd0);
    check("reset_retire", {16'd0, retire_count}, 32'd0);
    check("reset_state", {30'd0, state}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = AW'(i);
      #1;
      check("reset_reg", {16'd0, rd_data_a}, 32'd0);
    end

    // Table vectors, issued back to back.
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i], 16'(i + 1), 1'b1);
    end
    repeat (4) @(posedge clk);
    #1;

    // Two back-to-back writes to r1; observe r1 and flags during the 2nd commit.
    rd_addr_a = 3'd1;
    issue(mk(3'd1, 16'h0011, 1, 4'b0000, 0, MEM_NONE, 16'h0, 16'h0, 16'h0, 0, 16'h0011, 4'b0000), 16'd13, 1'b1);
    issue(mk(3'd1, 16'h0022, 1, 4'b1100, 1, MEM_NONE, 16'h0, 16'h0, 16'h0, 0, 16'h0022, 4'b1100), 16'd14, 1'b1);
    @(negedge clk);
    check("second_commit_state", {30'd0, state}, 32'd2);
`ifdef WB_BYPASS_EN
    check("bypass_rd_a", {16'd0, rd_data_a}, 32'h0022);
    check("bypass_flags", {28'd0, flags}, 32'hC);
`else
    check("no_bypass_rd_a", {16'd0, rd_data_a}, 32'h0011);
    check("no_bypass_flags", {28'd0, flags}, 32'h0);
`endif
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of an access, then a stray ack in IDLE.
    resp_en = 1'b0;
    issue(mk(3'd5, 16'h0, 1, 4'b0000, 0, MEM_LOAD, 16'h0080, 16'h0, 16'h0, 0, 16'h0, 4'b0000), 16'd0, 1'b0);
    @(negedge clk);
    check("abandon_req_high", {31'd0, mem_bus.mem_req}, 32'd1);
    check("abandon_ready_low", {31'd0, ex_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abandon_req_low", {31'd0, mem_bus.mem_req}, 32'd0);
    check("abandon_state", {30'd0, state}, 32'd0);
    check("abandon_ready", {31'd0, ex_ready}, 32'd1);
    check("abandon_flags", {28'd0, flags}, 32'd0);
    check("abandon_retire", {16'd0, retire_count}, 32'd0);
    check("abandon_mem_addr", {16'd0, mem_bus.mem_addr}, 32'd0);
    @(posedge clk);
    #1 stray_ack = 1'b1;
    @(posedge clk);
    #1 stray_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_state", {30'd0, state}, 32'd0);
    check("stray_ack_retire", {16'd0, retire_count}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = AW'(i);
      #1;
      check("abandon_reg", {16'd0, rd_data_a}, 32'd0);
    end
    resp_en = 1'b1;
    @(posedge clk);
    #1;

    // Retire 65535 NOPs, then one more instruction to wrap the counter.
    monitor_en = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      issue(nop, 16'd0, 1'b0);
      if (timed_out) break;
    end
    @(posedge clk);
    #1;
    check("retire_before_wrap", {16'd0, retire_count}, 32'hFFFF);
    monitor_en = 1'b1;
    issue(mk(3'd4, 16'h0BAD, 1, 4'b0000, 0, MEM_NONE, 16'h0, 16'h0, 16'h0, 0, 16'h0BAD, 4'b0000), 16'h0000, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    check("exp_q_drained", exp_q.size(), 32'd0);
    check("acc_q_drained", acc_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and writeback stage of the SCC core, directly downstream of the execute stage. Accepts one executed instruction per handshake, performs an optional load/store over a req/ack memory port, then commits the result to the 8x16 register file and the 4-bit flags register. Also serves execute's operand reads and flags input, and counts retired instructions.

## Interface
- DATA_W, 16, register/data/address width
- REG_AW, 3, register index width (2**REG_AW = 8 registers)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  stage can accept this cycle
- ex_result  in  DATA_W  ALU result (ignored for loads)
- ex_dest_reg  in  REG_AW  destination register
- ex_wr_en  in  1  instruction writes ex_dest_reg
- ex_flags  in  4  new flags {N,Z,C,V}
- ex_flags_en  in  1  instruction updates flags
- ex_mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- ex_addr  in  DATA_W  effective address (pointer_reg + offset)
- ex_store_data  in  DATA_W  store data
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- mem_addr  out  DATA_W  request address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- mem_ack  in  1  request complete
- rd_addr_a, rd_addr_b  in  REG_AW  operand read indices from decode/execute
- rd_data_a, rd_data_b  out  DATA_W  combinational read data
- flags  out  4  architectural flags to execute
- retire_count  out  16  retired-instruction counter

## Operation
- Clock is clk; reset is rst, synchronous and active-high.
- FSM states IDLE, ACCESS, COMMIT. ex_ready = (state != ACCESS).
- Accept = ex_valid & ex_ready: latch all ex_* fields into the stage register.
- IDLE/COMMIT on accept: mem_op none/reserved -> COMMIT; load/store -> ACCESS. No accept: COMMIT -> IDLE, IDLE stays.
- ACCESS: mem_req=1; mem_we, mem_addr, mem_wdata driven from the latched fields and held stable until mem_ack. On mem_ack, a load captures mem_rdata as the result; go to COMMIT. mem_req drops the cycle after ack.
- COMMIT (one cycle): write result to dest if wr_en; stores never write registers; loads write only if wr_en. Update flags if flags_en; loads never update flags. Increment retire_count (wraps 0xFFFF -> 0x0000).
- A new accept in COMMIT is legal: the commit and the new latch happen on the same edge.
- All 8 registers are writable; no hardwired zero.
- Reset values: registers 0, flags 0, retire_count 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, state IDLE, so ex_ready=1 the cycle after reset.
- Reset during ACCESS abandons the transaction: mem_req=0 the next cycle and any later mem_ack is ignored in IDLE.

## Timing
- Non-memory instruction: accepted at edge N, committed at edge N+1, visible on rd_data/flags after N+1. Throughput is 1 per cycle.
- Memory instruction: mem_req is high from the cycle after accept. An ack in the same cycle as req yields commit one edge later, so a zero-wait access takes 3 edges from accept to commit.
- rd_data_a/b and flags are combinational from the architectural state.

## Configuration
- WB_BYPASS_EN defined: when a COMMIT write targets rd_addr_a/b in the same cycle, rd_data_* returns the value being written, and flags returns the committing flags when flags_en.
- WB_BYPASS_EN undefined: reads return pre-write state; the write becomes visible the next cycle.

## Structure
- scc_pkg: mem_op_t encoding, wb_state_t enum, flag bit indices (N=3, Z=2, C=1, V=0), DATA_W/REG_AW defaults.
- Sub-module scc_reg_file: 8xDATA_W with two combinational read ports, one synchronous write port and the optional bypass. The FSM, flags register and counter stay in mem_wb_stage.

## Test plan
- Reset, then add with dest=3, result=0x1234, wr_en=1, flags_en=1, flags=4'b0100 -> after commit rd_data_a(3)=0x1234, flags=0100, retire_count=1.
- Load from addr 0x0040 with dest=5 and mem_ack delayed 3 cycles with rdata=0xBEEF -> mem_req held 3 cycles with addr stable, ex_ready=0 throughout, r5=0xBEEF, flags unchanged.
- Store 0xA5A5 to 0x0010 -> mem_we=1, mem_wdata=0xA5A5, no register or flags change, retire_count increments.
- Back-to-back non-memory writes r1=1 then r1=2 on consecutive cycles -> r1=2, retire_count +2. With WB_BYPASS_EN, rd_addr_a=1 during the second commit shows 2.
- rst asserted during ACCESS, then a stray mem_ack -> mem_req=0 next cycle, all state zero, no commit.
- Preload retire_count to 0xFFFF (via 65535 NOPs or force) and retire one more instruction -> retire_count=0x0000.
